i1_router_out_arbiter: RTL and testbench
========================================

Name: i1_router_out_arbiter

Overview:
- Output-port scheduler for the i1 router. One instance per output link.
- Shares the link between NUM_IN input FIFOs, which are filled by the per-port write controllers.
- Packets are two flits: head code 3'b001, then payload code 3'b110. A grant is locked from the head flit through the payload flit.
- Round-robin fairness, stray-flit flushing, and a payload watchdog so a stalled packet cannot hold the link.

Parameters:
- NUM_IN, 4, number of input FIFOs arbitrated (2..8).
- SEL_W, 2, width of out_sel; equals ceil(log2(NUM_IN)).
- TIMEOUT, 15, cycles a granted FIFO may stay empty in BODY before the grant is revoked (1..255).

Ports:
- clk  in  1  router clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fifo_empty  in  NUM_IN  per-FIFO empty flag.
- fifo_head  in  3*NUM_IN  head code of each FIFO's front flit; FIFO i occupies bits [3i+2:3i]; valid only when not empty.
- out_bussy  in  1  downstream busy; no flit transfers while high.
- fifo_rd  out  NUM_IN  per-FIFO pop strobe, combinational, at most one bit high except during flush.
- grant  out  NUM_IN  registered one-hot grant, zero when idle.
- out_sel  out  SEL_W  registered index of the granted FIFO, drives the datapath mux.
- out_req  out  1  flit valid toward downstream, combinational.
- pkt_err  out  1  registered one-cycle pulse on timeout or malformed payload.
- err_cnt  out  8  saturating count of pkt_err pulses.

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE, grant=0, out_sel=0, rr_ptr=0, watchdog=0, pkt_err=0, err_cnt=0. Combinational outputs resolve to fifo_rd=0 and out_req=0.
- Definitions:
  - cand[i] = ~fifo_empty[i] & (fifo_head[i]==3'b001).
  - stray[i] = ~fifo_empty[i] & (fifo_head[i]!=3'b001).
- IDLE:
  - out_req=0.
  - fifo_rd[i]=stray[i] for all i. Stray flits are flushed in parallel, one per FIFO per cycle, and are not counted as errors.
  - If any cand bit is set and out_bussy is low, the winner w is the first cand index at or after rr_ptr, searching upward with wraparound.
  - At the clock edge: grant<=onehot(w), out_sel<=w, rr_ptr<=(w+1) mod NUM_IN, state<=HEAD.
  - If out_bussy is high, there is no grant and rr_ptr is unchanged.
- HEAD:
  - out_req=1.
  - fifo_rd[w]=~out_bussy.
  - When ~out_bussy, the head flit transfers and state<=BODY with watchdog<=0. Otherwise hold.
- BODY:
  - fifo_head[w]==3'b110 and not empty: out_req=1 and fifo_rd[w]=~out_bussy. When the transfer occurs, state<=IDLE and grant<=0 on the same edge.
  - fifo_head[w]==3'b001 and not empty (malformed packet): no read, out_req=0, pkt_err pulse, state<=IDLE, grant<=0.
  - FIFO w empty: out_req=0 and watchdog increments. When watchdog==TIMEOUT-1 and FIFO w is still empty: pkt_err pulse, state<=IDLE, grant<=0.
  - The watchdog does not count while out_bussy stalls a ready payload flit.
- Latency: the grant registers one cycle after a head flit is present. The minimum packet takes 3 cycles (IDLE, HEAD, BODY), and the next grant can register on the cycle after the BODY transfer.
- Simultaneous events: a new head arriving at another FIFO during HEAD/BODY waits; the lock is never pre-empted. In IDLE, a FIFO cannot be both cand and stray.
- err_cnt increments with each pkt_err and saturates at 255.
- Reset mid-packet: grant drops immediately and asynchronously, and the partially sent packet is not resumed.

Test Plan:
- Single packet: FIFO2 holds 001 then 110, out_bussy=0 -> grant=4'b0100 in cycle 1, fifo_rd[2] high in cycles 1 and 2, grant=0 in cycle 3, rr_ptr=3.
- All four FIFOs hold packets, rr_ptr=0 -> grants are served in order 0,1,2,3 with no gaps beyond 1 idle cycle per packet; then FIFO0 refilled -> served next.
- out_bussy held high 5 cycles during HEAD -> fifo_rd=0, grant stable; on release the head and payload transfer on consecutive non-busy cycles.
- FIFO1 emptied after head, TIMEOUT=15 -> pkt_err pulses exactly 15 cycles into BODY, err_cnt=1, grant=0 next cycle.
- FIFO3 front=3'b110 in IDLE -> flushed (fifo_rd[3]=1 one cycle), no grant; payload code 001 in BODY -> pkt_err, no read.
- Assert rst_n low during BODY -> grant, out_sel, pkt_err go to 0 asynchronously; err_cnt=0; after release the arbiter restarts from rr_ptr=0.

Source files
------------

// File: rtl/i1_router_out_arbiter.sv
// Output-link scheduler for the i1 router: round-robin grant over NUM_IN input FIFOs,
// locked for one two-flit packet, with stray-flit flushing and a payload watchdog.
module i1_router_out_arbiter #(
  parameter int NUM_IN  = 4,
  parameter int SEL_W   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IN-1:0]   fifo_empty,
  input  logic [3*NUM_IN-1:0] fifo_head,
  input  logic                out_bussy,
  output logic [NUM_IN-1:0]   fifo_rd,
  output logic [NUM_IN-1:0]   grant,
  output logic [SEL_W-1:0]    out_sel,
  output logic                out_req,
  output logic                pkt_err,
  output logic [7:0]          err_cnt
);

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  state_t              r_state;
  logic [NUM_IN-1:0]   r_grant;
  logic [SEL_W-1:0]    r_sel;
  logic [SEL_W-1:0]    r_rr;
  logic [7:0]          r_wd;
  logic                r_err;
  logic [7:0]          r_cnt;

  logic [NUM_IN-1:0]   w_cand;
  logic [NUM_IN-1:0]   w_stray;
  logic [SEL_W-1:0]    w_win;
  logic                w_found;
  logic [SEL_W:0]      w_sum;
  logic [2:0]          w_whead;
  logic                w_wempty;
  logic                w_pay;
  logic                w_bad;
  logic                w_tout;
  logic                w_err;

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      w_cand[i]  = ~fifo_empty[i] & (fifo_head[3*i +: 3] == 3'b001);
      w_stray[i] = ~fifo_empty[i] & (fifo_head[3*i +: 3] != 3'b001);
    end
  end

  // Descending scan so the candidate closest at/after r_rr is the last writer.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    for (int k = NUM_IN-1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr} + (SEL_W+1)'(k);
      if (w_sum >= (SEL_W+1)'(NUM_IN)) w_sum = w_sum - (SEL_W+1)'(NUM_IN);
      if (w_cand[w_sum[SEL_W-1:0]]) begin
        w_win   = w_sum[SEL_W-1:0];
        w_found = 1'b1;
      end
    end
  end

  assign w_whead  = fifo_head[3*r_sel +: 3];
  assign w_wempty = fifo_empty[r_sel];
  assign w_pay    = (r_state == BODY) & ~w_wempty & (w_whead == 3'b110);
  assign w_bad    = (r_state == BODY) & ~w_wempty & (w_whead != 3'b110);
  assign w_tout   = (r_state == BODY) & w_wempty & (r_wd == 8'(TIMEOUT-1));
  assign w_err    = w_bad | w_tout;

  always_comb begin
    fifo_rd = '0;
    out_req = 1'b0;
    case (r_state)
      IDLE: fifo_rd = w_stray;
      HEAD: begin
        out_req = 1'b1;
        fifo_rd = out_bussy ? '0 : r_grant;
      end
      BODY: if (w_pay) begin
        out_req = 1'b1;
        fifo_rd = out_bussy ? '0 : r_grant;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_sel   <= '0;
      r_rr    <= '0;
      r_wd    <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_err <= w_err;
      if (w_err && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
      case (r_state)
        IDLE: if (w_found && !out_bussy) begin
          r_grant <= NUM_IN'(1) << w_win;
          r_sel   <= w_win;
          r_rr    <= (w_win == SEL_W'(NUM_IN-1)) ? '0 : w_win + 1'b1;
          r_state <= HEAD;
        end
        HEAD: if (!out_bussy) begin
          r_state <= BODY;
          r_wd    <= '0;
        end
        BODY: begin
          if (w_err || (w_pay && !out_bussy)) begin
            r_state <= IDLE;
            r_grant <= '0;
          end else if (w_wempty) begin
            r_wd <= r_wd + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant   = r_grant;
  assign out_sel = r_sel;
  assign pkt_err = r_err;
  assign err_cnt = r_cnt;

endmodule

// File: tb/tb_i1_router_out_arbiter.sv
// Bench for i1_router_out_arbiter: directed scenarios plus random traffic against a packet-level model.
module tb_i1_router_out_arbiter;
  localparam int N  = 4;
  localparam int TO = 15;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   fifo_empty;
  logic [3*N-1:0] fifo_head;
  logic           out_bussy;
  logic [N-1:0]   fifo_rd;
  logic [N-1:0]   grant;
  logic [1:0]     out_sel;
  logic           out_req;
  logic           pkt_err;
  logic [7:0]     err_cnt;

  i1_router_out_arbiter #(.NUM_IN(N), .SEL_W(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_head(fifo_head),
    .out_bussy(out_bussy), .fifo_rd(fifo_rd), .grant(grant), .out_sel(out_sel),
    .out_req(out_req), .pkt_err(pkt_err), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [2:0] q [N][$];
  logic       need_pay [N];

  // packet-level reference: owner index (-1 idle), head sent, empty cycles seen in body
  int         m_own, m_rr, m_sel, m_empt, m_cnt;
  logic       m_hs, m_err, m_req;
  logic [N-1:0] m_rd;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      fifo_empty[i] = (q[i].size() == 0);
      fifo_head[3*i +: 3] = (q[i].size() == 0) ? 3'b000 : q[i][0];
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_rr = 0; m_sel = 0; m_empt = 0; m_cnt = 0;
    m_hs = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_comb();
    m_rd = '0;
    m_req = 1'b0;
    if (m_own < 0) begin
      for (int i = 0; i < N; i++)
        if (q[i].size() > 0 && q[i][0] != 3'b001) m_rd[i] = 1'b1;
    end else if (!m_hs) begin
      m_req = 1'b1;
      m_rd[m_own] = !out_bussy;
    end else if (q[m_own].size() > 0 && q[m_own][0] == 3'b110) begin
      m_req = 1'b1;
      m_rd[m_own] = !out_bussy;
    end
  endtask

  task automatic model_update();
    m_err = 1'b0;
    if (m_own < 0) begin
      if (!out_bussy)
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_rr + k) % N;
          if (m_own < 0 && q[idx].size() > 0 && q[idx][0] == 3'b001) begin
            m_own = idx; m_sel = idx; m_rr = (idx + 1) % N; m_hs = 1'b0;
          end
        end
    end else if (!m_hs) begin
      if (!out_bussy) begin m_hs = 1'b1; m_empt = 0; end
    end else if (q[m_own].size() == 0) begin
      m_empt++;
      if (m_empt == TO) begin m_err = 1'b1; m_own = -1; end
    end else if (q[m_own][0] == 3'b110) begin
      if (!out_bussy) m_own = -1;
    end else begin
      m_err = 1'b1; m_own = -1;
    end
    if (m_err && m_cnt < 255) m_cnt++;
  endtask

  task automatic gen_random();
    for (int i = 0; i < N; i++) begin
      if (q[i].size() < 4 && $urandom_range(0, 99) < 35) begin
        if (need_pay[i]) begin
          if ($urandom_range(0, 99) < 92) begin q[i].push_back(3'b110); need_pay[i] = 1'b0; end
          else q[i].push_back(3'b001);
        end else begin
          if ($urandom_range(0, 99) < 90) begin q[i].push_back(3'b001); need_pay[i] = 1'b1; end
          else q[i].push_back(3'b110);
        end
      end
    end
    out_bussy = ($urandom_range(0, 99) < 25);
  endtask

  // one clock: pops on the edge, then new inputs at the falling edge; returns at negedge+1
  task automatic cyc(input logic use_model);
    logic [N-1:0] rd;
    rd = use_model ? m_rd : fifo_rd;
    @(posedge clk);
    if (use_model) model_update();
    for (int i = 0; i < N; i++)
      if (rd[i] && q[i].size() > 0) void'(q[i].pop_front());
    @(negedge clk);
    if (use_model) gen_random();
    drive();
    #1;
    if (use_model) model_comb();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    out_bussy = 1'b0;
    for (int i = 0; i < N; i++) begin q[i].delete(); need_pay[i] = 1'b0; end
    drive();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic push_pkt(input int i);
    q[i].push_back(3'b001);
    q[i].push_back(3'b110);
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", grant); else n_pass++;
    n_chk++; if (out_sel !== 2'd0) $display("FAIL reset_sel: got %0d want 0", out_sel); else n_pass++;
    n_chk++; if (pkt_err !== 1'b0 || err_cnt !== 8'd0) $display("FAIL reset_err: got %b/%0d want 0/0", pkt_err, err_cnt); else n_pass++;
    n_chk++; if (fifo_rd !== 4'b0000 || out_req !== 1'b0) $display("FAIL reset_comb: got rd=%b req=%b want 0000/0", fifo_rd, out_req); else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    push_pkt(2); drive(); #1;
    n_chk++; if (fifo_rd !== 4'b0000 || grant !== 4'b0000) $display("FAIL single_idle: got rd=%b g=%b want 0000/0000", fifo_rd, grant); else n_pass++;
    cyc(0);
    n_chk++; if (grant !== 4'b0100 || out_sel !== 2'd2) $display("FAIL single_grant: got %b/%0d want 0100/2", grant, out_sel); else n_pass++;
    n_chk++; if (fifo_rd !== 4'b0100 || out_req !== 1'b1) $display("FAIL single_head_rd: got %b/%b want 0100/1", fifo_rd, out_req); else n_pass++;
    cyc(0);
    n_chk++; if (fifo_rd !== 4'b0100 || out_req !== 1'b1) $display("FAIL single_body_rd: got %b/%b want 0100/1", fifo_rd, out_req); else n_pass++;
    cyc(0);
    n_chk++; if (grant !== 4'b0000) $display("FAIL single_release: got %b want 0000", grant); else n_pass++;
    push_pkt(0); push_pkt(3); drive(); #1;
    cyc(0);
    n_chk++; if (grant !== 4'b1000) $display("FAIL single_rr_next: got %b want 1000", grant); else n_pass++;
    cyc(0); cyc(0); cyc(0);
    n_chk++; if (grant !== 4'b0001) $display("FAIL single_rr_wrap: got %b want 0001", grant); else n_pass++;
    cyc(0); cyc(0);
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) push_pkt(i);
    drive(); #1;
    for (int k = 0; k < N; k++) begin
      n_chk++; if (grant !== 4'b0000) $display("FAIL rr_gap%0d: got %b want 0000", k, grant); else n_pass++;
      cyc(0);
      n_chk++; if (grant !== (4'b0001 << k) || out_sel !== 2'(k)) $display("FAIL rr_grant%0d: got %b/%0d want %b/%0d", k, grant, out_sel, 4'b0001 << k, k); else n_pass++;
      cyc(0); cyc(0);
    end
    push_pkt(1); push_pkt(0); drive(); #1;
    cyc(0);
    n_chk++; if (grant !== 4'b0001) $display("FAIL rr_refill: got %b want 0001", grant); else n_pass++;
    repeat (5) cyc(0);
  endtask

  task automatic test_busy();
    do_reset();
    push_pkt(1); out_bussy = 1'b1; drive(); #1;
    cyc(0); cyc(0);
    n_chk++; if (grant !== 4'b0000) $display("FAIL busy_idle_grant: got %b want 0000", grant); else n_pass++;
    out_bussy = 1'b0; #1;
    cyc(0);
    n_chk++; if (grant !== 4'b0010) $display("FAIL busy_grant: got %b want 0010", grant); else n_pass++;
    out_bussy = 1'b1; #1;
    for (int k = 0; k < 5; k++) begin
      n_chk++; if (fifo_rd !== 4'b0000 || grant !== 4'b0010 || out_req !== 1'b1)
        $display("FAIL busy_hold%0d: got rd=%b g=%b req=%b want 0000/0010/1", k, fifo_rd, grant, out_req); else n_pass++;
      cyc(0);
    end
    out_bussy = 1'b0; #1;
    n_chk++; if (fifo_rd !== 4'b0010) $display("FAIL busy_head_go: got %b want 0010", fifo_rd); else n_pass++;
    cyc(0);
    n_chk++; if (fifo_rd !== 4'b0010 || out_req !== 1'b1) $display("FAIL busy_body_go: got %b/%b want 0010/1", fifo_rd, out_req); else n_pass++;
    cyc(0);
    n_chk++; if (grant !== 4'b0000) $display("FAIL busy_release: got %b want 0000", grant); else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    q[1].push_back(3'b001); drive(); #1;
    cyc(0); cyc(0);
    for (int k = 0; k < TO; k++) begin
      n_chk++; if (pkt_err !== 1'b0 || grant !== 4'b0010 || out_req !== 1'b0)
        $display("FAIL tout_wait%0d: got err=%b g=%b req=%b want 0/0010/0", k, pkt_err, grant, out_req); else n_pass++;
      cyc(0);
    end
    n_chk++; if (pkt_err !== 1'b1 || grant !== 4'b0000 || err_cnt !== 8'd1)
      $display("FAIL tout_fire: got err=%b g=%b cnt=%0d want 1/0000/1", pkt_err, grant, err_cnt); else n_pass++;
    cyc(0);
    n_chk++; if (pkt_err !== 1'b0 || err_cnt !== 8'd1) $display("FAIL tout_pulse: got %b/%0d want 0/1", pkt_err, err_cnt); else n_pass++;
  endtask

  task automatic test_stray_malformed();
    do_reset();
    q[3].push_back(3'b110);
    q[0].push_back(3'b001); q[0].push_back(3'b001); q[0].push_back(3'b110);
    drive(); #1;
    n_chk++; if (fifo_rd !== 4'b1000 || grant !== 4'b0000) $display("FAIL stray_flush: got rd=%b g=%b want 1000/0000", fifo_rd, grant); else n_pass++;
    cyc(0);
    n_chk++; if (fifo_rd !== 4'b0001 || grant !== 4'b0001) $display("FAIL stray_then_head: got rd=%b g=%b want 0001/0001", fifo_rd, grant); else n_pass++;
    cyc(0);
    n_chk++; if (fifo_rd !== 4'b0000 || out_req !== 1'b0 || pkt_err !== 1'b0) $display("FAIL bad_body: got rd=%b req=%b err=%b want 0000/0/0", fifo_rd, out_req, pkt_err); else n_pass++;
    cyc(0);
    n_chk++; if (pkt_err !== 1'b1 || grant !== 4'b0000 || err_cnt !== 8'd1) $display("FAIL bad_err: got err=%b g=%b cnt=%0d want 1/0000/1", pkt_err, grant, err_cnt); else n_pass++;
    cyc(0);
    n_chk++; if (grant !== 4'b0001 || pkt_err !== 1'b0) $display("FAIL bad_regrant: got g=%b err=%b want 0001/0", grant, pkt_err); else n_pass++;
    cyc(0); cyc(0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    q[2].push_back(3'b001); q[2].push_back(3'b001); drive(); #1;
    repeat (5) cyc(0);
    n_chk++; if (grant !== 4'b0100 || err_cnt !== 8'd1) $display("FAIL rmid_pre: got g=%b cnt=%0d want 0100/1", grant, err_cnt); else n_pass++;
    rst_n = 1'b0; #1;
    n_chk++; if (grant !== 4'b0000 || out_sel !== 2'd0 || pkt_err !== 1'b0 || err_cnt !== 8'd0)
      $display("FAIL rmid_async: got g=%b sel=%0d err=%b cnt=%0d want 0000/0/0/0", grant, out_sel, pkt_err, err_cnt); else n_pass++;
    push_pkt(3); push_pkt(1); drive();
    @(negedge clk); rst_n = 1'b1; #1;
    n_chk++; if (grant !== 4'b0000 || fifo_rd !== 4'b0000) $display("FAIL rmid_idle: got g=%b rd=%b want 0000/0000", grant, fifo_rd); else n_pass++;
    cyc(0);
    n_chk++; if (grant !== 4'b0010) $display("FAIL rmid_restart: got %b want 0010", grant); else n_pass++;
    repeat (6) cyc(0);
  endtask

  task automatic test_random();
    logic [N-1:0] eg;
    do_reset();
    model_comb();
    for (int c = 0; c < 1500; c++) begin
      eg = (m_own < 0) ? '0 : (4'b0001 << m_own);
      n_chk++; if (fifo_rd !== m_rd) $display("FAIL rnd_rd c%0d: got %b want %b", c, fifo_rd, m_rd); else n_pass++;
      n_chk++; if (out_req !== m_req) $display("FAIL rnd_req c%0d: got %b want %b", c, out_req, m_req); else n_pass++;
      n_chk++; if (grant !== eg || out_sel !== 2'(m_sel)) $display("FAIL rnd_grant c%0d: got %b/%0d want %b/%0d", c, grant, out_sel, eg, m_sel); else n_pass++;
      n_chk++; if (pkt_err !== m_err || err_cnt !== 8'(m_cnt)) $display("FAIL rnd_err c%0d: got %b/%0d want %b/%0d", c, pkt_err, err_cnt, m_err, m_cnt); else n_pass++;
      cyc(1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    out_bussy = 1'b0;
    fifo_empty = '1;
    fifo_head = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_busy();
    test_timeout();
    test_stray_malformed();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
